// File: rtl/pc_ctrl_unit.sv
// Program-counter sequencer and branch resolver: advances the fetch PC,
// resolves JMP/JEQ/JLT against lane-0 compare flags, and latches END.
module pc_ctrl_unit #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IMM_W = 18,
  parameter int unsigned LANES = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       FlagsWrite,
  input  logic [3:0]                 Id,
  input  logic [LANES-1:0][1:0]      ALUFlags,
  input  logic [IMM_W-1:0]           Imm,
  output logic                       EndFlag,
  output logic                       COMFlag,
  output logic [PC_W-1:0]            PCNext
);

  localparam int unsigned FLAG_W = 2;
  localparam logic [3:0]  OP_JMP = 4'hC;
  localparam logic [3:0]  OP_JEQ = 4'hD;
  localparam logic [3:0]  OP_JLT = 4'hE;
  localparam logic [3:0]  OP_END = 4'hF;

  typedef enum logic {
    ST_RUN,
    ST_END
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [FLAG_W-1:0]   flag_q, flag_d;
  logic [FLAG_W-1:0]   eff_flags;
  logic                take;

  // Only lane 0 carries the scalar compare result.
  generate
    if (LANES > 1) begin : g_unused_lanes
      logic unused_lanes;
      assign unused_lanes = ^ALUFlags[LANES-1:1];
    end
  endgenerate

  // Bypass lets a compare and its dependent branch resolve in one cycle.
  assign eff_flags = FlagsWrite ? ALUFlags[0] : flag_q;

  assign take = (Id == OP_JMP)
              | ((Id == OP_JEQ) & eff_flags[0])
              | ((Id == OP_JLT) & eff_flags[1]);

  assign COMFlag = take & start & (state_q == ST_RUN);
  assign EndFlag = (state_q == ST_END);
  assign PCNext  = pc_q;

  // Next-state, PC and flag-register selection in priority order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    if (start && FlagsWrite) begin
      flag_d = ALUFlags[0];
    end
    case (state_q)
      ST_RUN: begin
        if (start) begin
          if (Id == OP_END) begin
            state_d = ST_END;
          end else if (take) begin
            pc_d = PC_W'(Imm);
          end else begin
            pc_d = pc_q + PC_W'(4);
          end
        end
      end
      ST_END: begin
        state_d = ST_END;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
    end
  end

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Bench for pc_ctrl_unit: directed vector table, async-reset and wrap
// sequences, then randomized cycles against an instruction-level model.
module tb_pc_ctrl_unit;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned IMM_W = 18;
  localparam int unsigned LANES = 6;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic                  fw;
  logic [3:0]            id;
  logic [LANES-1:0][1:0] alu;
  logic [IMM_W-1:0]      imm;
  logic                  end_flag;
  logic                  com_flag;
  logic [PC_W-1:0]       pc;

  // Narrow instance used to reach the PC wrap boundary.
  logic                  s_reset;
  logic                  s_start;
  logic                  s_fw;
  logic [3:0]            s_id;
  logic [1:0][1:0]       s_alu;
  logic [7:0]            s_imm;
  logic                  s_end;
  logic                  s_com;
  logic [7:0]            s_pc;

  int checks = 0;
  int errors = 0;

  pc_ctrl_unit #(.PC_W(PC_W), .IMM_W(IMM_W), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .start(start), .FlagsWrite(fw), .Id(id),
    .ALUFlags(alu), .Imm(imm), .EndFlag(end_flag), .COMFlag(com_flag),
    .PCNext(pc)
  );

  pc_ctrl_unit #(.PC_W(8), .IMM_W(8), .LANES(2)) dut_small (
    .clk(clk), .reset(s_reset), .start(s_start), .FlagsWrite(s_fw), .Id(s_id),
    .ALUFlags(s_alu), .Imm(s_imm), .EndFlag(s_end), .COMFlag(s_com),
    .PCNext(s_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        fw;
    logic [3:0]  id;
    logic [1:0]  f0;
    logic [1:0]  f1;
    logic [17:0] imm;
    logic        exp_com;
    logic [31:0] exp_pc;
    logic        exp_end;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at a negedge; COMFlag before the edge, state after.
  task automatic apply(input vec_t v, input int idx);
    start = v.st;
    fw    = v.fw;
    id    = v.id;
    alu   = '0;
    alu[0] = v.f0;
    alu[1] = v.f1;
    imm   = v.imm;
    #1;
    check($sformatf("vec%0d_com", idx), 32'(com_flag), 32'(v.exp_com));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_pc", idx), pc, v.exp_pc);
    check($sformatf("vec%0d_end", idx), 32'(end_flag), 32'(v.exp_end));
    @(negedge clk);
  endtask

  // Reference model state: architectural PC, halted bit, stored compare flags.
  logic [31:0] m_pc;
  logic        m_end;
  logic [1:0]  m_flags;

  vec_t vecs[18];

  initial begin
    reset = 1'b0; start = 1'b0; fw = 1'b0; id = 4'h0; alu = '0; imm = '0;
    s_reset = 1'b0; s_start = 1'b0; s_fw = 1'b0; s_id = 4'h0; s_alu = '0; s_imm = '0;

    //          st  fw  id     f0     f1     imm       com   pc          end
    vecs[0]  = '{1, 0, 4'h6, 2'b00, 2'b00, 18'h0,    1'b0, 32'h4,      1'b0};
    vecs[1]  = '{1, 0, 4'h6, 2'b00, 2'b00, 18'h0,    1'b0, 32'h8,      1'b0};
    vecs[2]  = '{1, 0, 4'h6, 2'b00, 2'b00, 18'h0,    1'b0, 32'hC,      1'b0};
    vecs[3]  = '{1, 0, 4'hC, 2'b00, 2'b00, 18'h50,   1'b1, 32'h50,     1'b0};
    vecs[4]  = '{1, 1, 4'hD, 2'b01, 2'b00, 18'h13C,  1'b1, 32'h13C,    1'b0};
    vecs[5]  = '{1, 1, 4'h6, 2'b10, 2'b00, 18'h0,    1'b0, 32'h140,    1'b0};
    vecs[6]  = '{1, 0, 4'hD, 2'b00, 2'b00, 18'h200,  1'b0, 32'h144,    1'b0};
    vecs[7]  = '{1, 1, 4'hE, 2'b10, 2'b00, 18'h94,   1'b1, 32'h94,     1'b0};
    vecs[8]  = '{1, 1, 4'hE, 2'b00, 2'b10, 18'h300,  1'b0, 32'h98,     1'b0};
    vecs[9]  = '{1, 0, 4'hE, 2'b00, 2'b00, 18'h300,  1'b0, 32'h9C,     1'b0};
    vecs[10] = '{0, 1, 4'hC, 2'b11, 2'b00, 18'h10,   1'b0, 32'h9C,     1'b0};
    vecs[11] = '{1, 0, 4'hD, 2'b00, 2'b00, 18'h40,   1'b0, 32'hA0,     1'b0};
    vecs[12] = '{1, 1, 4'hD, 2'b11, 2'b00, 18'h23,   1'b1, 32'h23,     1'b0};
    vecs[13] = '{1, 0, 4'hE, 2'b00, 2'b00, 18'h20,   1'b1, 32'h20,     1'b0};
    vecs[14] = '{1, 0, 4'hF, 2'b00, 2'b00, 18'h0,    1'b0, 32'h20,     1'b1};
    vecs[15] = '{1, 0, 4'hC, 2'b00, 2'b00, 18'h50,   1'b0, 32'h20,     1'b1};
    vecs[16] = '{0, 0, 4'h6, 2'b00, 2'b00, 18'h0,    1'b0, 32'h20,     1'b1};
    vecs[17] = '{1, 1, 4'h6, 2'b11, 2'b00, 18'h3FFFF,1'b0, 32'h20,     1'b1};

    // Reset state
    @(negedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_end", 32'(end_flag), 32'h0);
    check("reset_com", 32'(com_flag), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) apply(vecs[i], i);

    // Asynchronous reset while halted, away from any clock edge
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_end", 32'(end_flag), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1; fw = 1'b0; id = 4'hD; alu = '0; imm = 18'h77;
    #1;
    check("rst_flags_cleared_com", 32'(com_flag), 32'h0);
    @(posedge clk);
    #1;
    check("rst_flags_cleared_pc", pc, 32'h4);
    @(negedge clk);

    // PC wrap on the narrow instance: jump to the last word, then step.
    s_reset = 1'b1;
    s_start = 1'b1; s_id = 4'hC; s_imm = 8'hFC;
    @(posedge clk);
    #1;
    check("wrap_jump_pc", 32'(s_pc), 32'hFC);
    @(negedge clk);
    s_id = 4'h6;
    @(posedge clk);
    #1;
    check("wrap_pc", 32'(s_pc), 32'h0);
    @(negedge clk);
    s_start = 1'b0;

    // Randomized cycles against the instruction-level model.
    reset = 1'b0;
    #1;
    m_pc = 32'h0; m_end = 1'b0; m_flags = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b0;
        #1;
        m_pc = 32'h0; m_end = 1'b0; m_flags = 2'b00;
        check("rnd_reset_pc", pc, m_pc);
        @(negedge clk);
        reset = 1'b1;
      end else begin
        logic [1:0] eff;
        logic       taken;
        start = ($urandom_range(0, 4) != 0);
        fw    = 1'($urandom_range(0, 1));
        id    = 4'($urandom_range(0, 15));
        for (int k = 0; k < int'(LANES); k++) alu[k] = 2'($urandom_range(0, 3));
        imm   = 18'($urandom);
        eff   = fw ? alu[0] : m_flags;
        case (id)
          4'hC:    taken = 1'b1;
          4'hD:    taken = eff[0];
          4'hE:    taken = eff[1];
          default: taken = 1'b0;
        endcase
        #1;
        check("rnd_com", 32'(com_flag), 32'(taken && start && !m_end));
        if (start && fw) m_flags = alu[0];
        if (start && !m_end) begin
          if (id == 4'hF)  m_end = 1'b1;
          else if (taken)  m_pc  = {14'h0, imm};
          else             m_pc  = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        check("rnd_pc", pc, m_pc);
        check("rnd_end", 32'(end_flag), 32'(m_end));
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
